alu_pipe_param: RTL and testbench
=================================

# alu_pipe_param

Parametrised, fully handshaked two-stage pipelined ALU. It is the successor to the fixed 8-bit pipelined ALU and adds the following:
- generic datapath width;
- valid/ready flow control with backpressure;
- barrel shifts by an amount taken from B;
- multi-precision add/subtract through an internal carry register;
- an opaque tag that travels with each operation.

It sits between an operand-issue front end and a writeback/result consumer.

## Interface
- WIDTH, 8: datapath width; power of two, ≥ 4.
- TAG_W, 4: width of the user tag carried alongside each operation; ≥ 1.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts the operation this cycle.
- opcode  in  4  operation select (see Operation).
- a, b  in  WIDTH  operands; the shift amount is b[$clog2(WIDTH)-1:0].
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- out_tag  out  TAG_W  tag of the operation in `result`.
- carry, overflow, zero, negative, illegal  out  1 each  flags for the operation in `result`.

## Operation
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT: ~a.
  - 6 SHL: logical left by amt.
  - 7 SHR: logical right by amt.
  - 8 ADC: a+b+cy.
  - 9 SBC: a−b−cy.
  - 10 ASR: arithmetic right by amt.
  - 11 CMP: flags of a−b; `result` returns a.
  - 12–15 are illegal.
- `cy` is the internal carry register. It is reset to 0 and updated only by ops 0, 1, 8, 9 and 11, with the carry flag value those ops produce.
- carry, by op class:
  - ADD/ADC: unsigned carry-out, bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB/SBC/CMP: unsigned borrow, i.e. a < b + cy_in (cy_in = 0 for SUB/CMP).
  - Shifts: the last bit shifted out; 0 when amt = 0.
  - Logic ops: 0.
- overflow: two's-complement overflow for ADD/ADC/SUB/SBC/CMP; 0 for all other ops.
- zero is (result == 0); for CMP it is computed from a−b.
- negative is the MSB of result; for CMP it is the MSB of a−b.
- Illegal opcode: result = 0, all flags 0 except illegal = 1, zero = 1. cy is unchanged. The tag passes through.
- Operations complete strictly in order, one per cycle at full throughput.
- The carry chain is exact for back-to-back ADC/SBC: each op sees the cy value written by the immediately preceding carry-updating op. No bubbles are needed.

## Timing
- Stage 1 is the input register (s1_valid, opcode, a, b, tag).
- Stage 2 is the output register. It is loaded with the combinational compute of stage 1 and drives every output directly.
- The transfer rule is:
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free.
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Latency: an op accepted at edge N appears with out_valid = 1 after edge N+1 when unstalled.
- Throughput: 1 op/cycle.
- cy updates on the same edge the op is loaded into stage 2, i.e. only when s1_valid && s2_free.
- Stall: with out_ready = 0, stage 2 holds. Stage 1 accepts one more op, then in_ready falls. Nothing is dropped or duplicated, and outputs stay stable while out_valid && !out_ready.
- Simultaneous output drain and input accept in the same cycle is legal and keeps full throughput.
- Reset, including mid-stream:
  - s1_valid, out_valid and cy are cleared to 0.
  - result, out_tag and all flags are cleared to 0.
  - in_ready = 1 while rst is held and from the first cycle after it.
  - In-flight operations are discarded.

## Structure
- Package alu_pipe_pkg holds:
  - the opcode enum (4-bit; ADD…CMP plus an ILLEGAL range check);
  - a localparam function for the shift-amount width, $clog2(WIDTH).
- Sub-module alu_pipe_core: purely combinational, parametrised by WIDTH.
  - Inputs: opcode, a, b, cy_in.
  - Outputs: result, carry, overflow, zero, negative, illegal, cy_update.
- Top level: the two register stages, the handshake logic and the cy register.

## Test plan
All scenarios use WIDTH = 8.
- ADD a=0xFF b=0x01 → result 0x00, carry=1, zero=1, overflow=0; cy=1.
- ADD 0xFF+0x01 then back-to-back ADC 0x00+0x00 → second result 0x01, carry=0. Then SBC 0x00−0x00 with cy=0 → 0x00, zero=1.
- SUB 0x80−0x01 → 0x7F, overflow=1, carry=0, negative=0. CMP 0x05 vs 0x07 → result 0x05, carry=1, negative=1, zero=0.
- ASR a=0x90 amt=2 → 0xE4, carry=0. SHL a=0x81 amt=1 → 0x02, carry=1. SHR a=0x03 amt=0 → 0x03, carry=0.
- Backpressure: issue tags 1, 2, 3 every cycle with out_ready=0 → in_ready falls after two accepts. Holding out_ready=1 afterwards delivers tags 1, 2, 3 in order, with result stable during the stall.
- Opcode 0xC → illegal=1, result 0x00, cy unchanged. Asserting rst with two ops in flight → out_valid=0, all outputs 0, cy=0, no stale result after release.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types and helpers for the parametrised pipelined ALU.
// Opcode encoding, flag bundle and shift-amount width helper.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_ADC = 4'd8,
        OP_SBC = 4'd9,
        OP_ASR = 4'd10,
        OP_CMP = 4'd11
    } op_e;

    localparam logic [3:0] OP_LAST = 4'd11;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
        logic illegal;
    } flags_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_LAST;
    endfunction

    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Issue/result handshake bundle between front end, ALU and writeback.
// master = front end + consumer side, slave = the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] out_tag;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             illegal;

    modport master (
        output in_valid, opcode, a, b, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag,
        input  carry, overflow, zero, negative, illegal
    );

    modport slave (
        input  in_valid, opcode, a, b, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag,
        output carry, overflow, zero, negative, illegal
    );
endinterface

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result, flags and carry-register update.
// Shifts use a one-bit guard so the last bit shifted out falls out free.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal,
    output logic             cy_update
);
    localparam int SW  = shamt_w(WIDTH);
    localparam int MSB = WIDTH - 1;

    op_e                op;
    logic [SW-1:0]      amt;
    logic               add_cin;
    logic               sub_bin;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl_x;
    logic [WIDTH:0]     shr_x;
    logic signed [WIDTH:0] asr_x;
    logic [WIDTH-1:0]   flag_src;

    assign op      = op_e'(opcode);
    assign amt     = b[SW-1:0];
    assign add_cin = (op == OP_ADC) && cy_in;
    assign sub_bin = (op == OP_SBC) && cy_in;
    assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
    assign diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_bin};
    assign shl_x   = {1'b0, a} << amt;
    assign shr_x   = {a, 1'b0} >> amt;
    assign asr_x   = $signed({a, 1'b0}) >>> amt;

    always_comb begin
        result    = '0;
        carry     = 1'b0;
        overflow  = 1'b0;
        illegal   = 1'b0;
        cy_update = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                result    = sum[MSB:0];
                carry     = sum[WIDTH];
                overflow  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
                cy_update = 1'b1;
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                result    = (op == OP_CMP) ? a : diff[MSB:0];
                carry     = diff[WIDTH];
                overflow  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
                cy_update = 1'b1;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = shl_x[MSB:0];
                carry  = shl_x[WIDTH];
            end
            OP_SHR: begin
                result = shr_x[WIDTH:1];
                carry  = shr_x[0];
            end
            OP_ASR: begin
                result = asr_x[WIDTH:1];
                carry  = asr_x[0];
            end
            default: illegal = 1'b1;
        endcase
        // CMP reports flags of the difference while returning a
        flag_src = (op == OP_CMP) ? diff[MSB:0] : result;
        zero     = (flag_src == '0);
        negative = flag_src[MSB];
    end

endmodule

// File: rtl/alu_pipe_param.sv
// Two-stage handshaked ALU: input register, compute, output register.
// The carry register advances when an op moves from stage 1 to stage 2.
module alu_pipe_param
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_res;
    logic [TAG_W-1:0] s2_tag;
    flags_t           s2_fl;
    logic             cy;

    logic [WIDTH-1:0] c_res;
    flags_t           c_fl;
    logic             c_cy_upd;
    logic             s2_free;
    logic             in_ready;

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .opcode    (s1_op),
        .a         (s1_a),
        .b         (s1_b),
        .cy_in     (cy),
        .result    (c_res),
        .carry     (c_fl.carry),
        .overflow  (c_fl.overflow),
        .zero      (c_fl.zero),
        .negative  (c_fl.negative),
        .illegal   (c_fl.illegal),
        .cy_update (c_cy_upd)
    );

    assign s2_free  = !s2_valid || bus.out_ready;
    assign in_ready = !s1_valid || s2_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op  <= bus.opcode;
                s1_a   <= bus.a;
                s1_b   <= bus.b;
                s1_tag <= bus.in_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_tag   <= '0;
            s2_fl    <= '0;
            cy       <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res <= c_res;
                s2_tag <= s1_tag;
                s2_fl  <= c_fl;
                if (c_cy_upd) cy <= c_fl.carry;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_res;
    assign bus.out_tag   = s2_tag;
    assign bus.carry     = s2_fl.carry;
    assign bus.overflow  = s2_fl.overflow;
    assign bus.zero      = s2_fl.zero;
    assign bus.negative  = s2_fl.negative;
    assign bus.illegal   = s2_fl.illegal;

endmodule

// File: tb/tb_alu_pipe_param.sv
// Scoreboard bench for alu_pipe_param at WIDTH=8, TAG_W=4.
// Flag vectors are {carry, overflow, zero, negative, illegal}.
module tb_alu_pipe_param;

    typedef struct packed {
        logic [3:0] tag;
        logic [7:0] res;
        logic [4:0] fl;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_pipe_if #(.WIDTH(8), .TAG_W(4)) bus ();

    alu_pipe_param #(.WIDTH(8), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] flags_now();
        return {bus.carry, bus.overflow, bus.zero,
                bus.negative, bus.illegal};
    endfunction

    task automatic chk(input string name,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: pops one expectation per output transfer
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        #1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            g = {bus.out_tag, bus.result, flags_now()};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got=%0h", g);
            end else begin
                e = sb.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL out_tag%0h got=%0h exp=%0h",
                             e.tag, g, e);
                end
            end
        end
    end

    task automatic send(input logic [3:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [3:0] tag,
                        input logic [7:0] res,
                        input logic [4:0] fl);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_tag   = tag;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout tag=%0h", tag);
        end else begin
            @(posedge clk);
            sb.push_back({tag, res, fl});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'h0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.in_tag    = 4'h0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 16'(bus.in_ready), 16'h1);
        chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_result", 16'(bus.result), 16'h0);
        chk("rst_flags", 16'(flags_now()), 16'h0);
        @(negedge clk);
        rst = 1'b0;

        send(4'd0,  8'hFF, 8'h01, 4'h1, 8'h00, 5'b10100);
        send(4'd8,  8'h00, 8'h00, 4'h2, 8'h01, 5'b00000);
        send(4'd9,  8'h00, 8'h00, 4'h3, 8'h00, 5'b00100);
        send(4'd1,  8'h80, 8'h01, 4'h4, 8'h7F, 5'b01000);
        send(4'd11, 8'h05, 8'h07, 4'h5, 8'h05, 5'b10010);
        send(4'd10, 8'h90, 8'h02, 4'h6, 8'hE4, 5'b00010);
        send(4'd6,  8'h81, 8'h01, 4'h7, 8'h02, 5'b10000);
        send(4'd7,  8'h03, 8'h00, 4'h8, 8'h03, 5'b00000);
        send(4'd2,  8'hF0, 8'h3C, 4'h9, 8'h30, 5'b00000);
        send(4'd3,  8'hF0, 8'h0F, 4'hA, 8'hFF, 5'b00010);
        send(4'd4,  8'hFF, 8'hFF, 4'hB, 8'h00, 5'b00100);
        send(4'd5,  8'h0F, 8'h00, 4'hC, 8'hF0, 5'b00010);
        send(4'hC,  8'h12, 8'h34, 4'hD, 8'h00, 5'b00101);
        send(4'd8,  8'h00, 8'h00, 4'hE, 8'h01, 5'b00000);
        idle();
        drain();

        // Backpressure: two accepts, then in_ready must drop
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(4'd3, 8'h01, 8'h00, 4'h1, 8'h01, 5'b00000);
        send(4'd3, 8'h02, 8'h00, 4'h2, 8'h02, 5'b00000);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = 4'd3;
        bus.a        = 8'h03;
        bus.b        = 8'h00;
        bus.in_tag   = 4'h3;
        #1;
        chk("bp_in_ready_low", 16'(bus.in_ready), 16'h0);
        chk("bp_out_valid", 16'(bus.out_valid), 16'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_result", 16'(bus.result), 16'h01);
            chk("bp_hold_tag", 16'(bus.out_tag), 16'h1);
            chk("bp_hold_ready", 16'(bus.in_ready), 16'h0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_back", 16'(bus.in_ready), 16'h1);
        @(posedge clk);
        sb.push_back({4'h3, 8'h03, 5'b00000});
        idle();
        drain();

        // Reset with two ops in flight, the first one setting cy
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(4'd0, 8'hFF, 8'h01, 4'h5, 8'h00, 5'b10100);
        send(4'd4, 8'h0F, 8'hF0, 4'h6, 8'hFF, 5'b00010);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_out_valid", 16'(bus.out_valid), 16'h0);
        chk("mid_rst_result", 16'(bus.result), 16'h0);
        chk("mid_rst_tag", 16'(bus.out_tag), 16'h0);
        chk("mid_rst_flags", 16'(flags_now()), 16'h0);
        chk("mid_rst_in_ready", 16'(bus.in_ready), 16'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_stale", 16'(bus.out_valid), 16'h0);
        end
        send(4'd8, 8'h00, 8'h00, 4'h7, 8'h00, 5'b00100);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
